// File: rtl/mult_div_unit.sv
// Execute-stage MIPS multiply/divide unit owning HI/LO; optional madd behind MDU_MADD_EN.
// Latency: MULT_CYCLES for mult/multu/madd, DIV_CYCLES for div/divu; mthi/mtlo take effect next edge.
// Backpressure: Busy is high while an op is in flight; Start, mthi and mtlo are ignored while Busy or Req.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start,
    input  logic [2:0]  MDUSelect,
    input  logic [1:0]  MFSelect,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] SEL_MULT  = 3'b000;
    localparam logic [2:0] SEL_MULTU = 3'b001;
    localparam logic [2:0] SEL_DIV   = 3'b010;
    localparam logic [2:0] SEL_DIVU  = 3'b011;
    localparam logic [2:0] SEL_MTHI  = 3'b100;
    localparam logic [2:0] SEL_MTLO  = 3'b101;
    localparam logic [2:0] SEL_MADD  = 3'b110;

    logic [CW-1:0] cnt;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   hi_n, lo_n;
    logic          commit_q;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_mag, b_mag, uq, ur, sq, sr;
    logic [63:0]        res;
    logic               res_ok;
    logic               launch_op;
    logic [CW-1:0]      res_cyc;

    assign Busy = (cnt != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        MDUOut = 32'h0;
        case (MFSelect)
            2'b00:   MDUOut = hi_q;
            2'b01:   MDUOut = lo_q;
            default: MDUOut = 32'h0;
        endcase
    end

    // Signed divide is done on magnitudes so 0x80000000 / -1 never overflows.
    always_comb begin
        prod_s    = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u    = {32'h0, A} * {32'h0, B};
        a_mag     = A[31] ? (~A + 32'd1) : A;
        b_mag     = B[31] ? (~B + 32'd1) : B;
        uq        = a_mag / b_mag;
        ur        = a_mag % b_mag;
        sq        = (A[31] ^ B[31]) ? (~uq + 32'd1) : uq;
        sr        = A[31] ? (~ur + 32'd1) : ur;
        res       = 64'h0;
        res_ok    = 1'b0;
        launch_op = 1'b0;
        res_cyc   = CW'(MULT_CYCLES);
        case (MDUSelect)
            SEL_MULT: begin
                res       = prod_s;
                res_ok    = 1'b1;
                launch_op = 1'b1;
            end
            SEL_MULTU: begin
                res       = prod_u;
                res_ok    = 1'b1;
                launch_op = 1'b1;
            end
            SEL_DIV: begin
                res       = {sr, sq};
                res_ok    = (B != 32'h0);
                launch_op = 1'b1;
                res_cyc   = CW'(DIV_CYCLES);
            end
            SEL_DIVU: begin
                res       = {A % B, A / B};
                res_ok    = (B != 32'h0);
                launch_op = 1'b1;
                res_cyc   = CW'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            SEL_MADD: begin
                res       = {hi_q, lo_q} + prod_s;
                res_ok    = 1'b1;
                launch_op = 1'b1;
            end
`endif
            default: begin
                launch_op = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
            hi_n     <= 32'h0;
            lo_n     <= 32'h0;
            commit_q <= 1'b0;
        end else if (Busy) begin
            // In-flight ops always finish; Req and new requests are ignored here.
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1) && commit_q) begin
                hi_q <= hi_n;
                lo_q <= lo_n;
            end
        end else if (!Req) begin
            if (Start && launch_op) begin
                {hi_n, lo_n} <= res;
                commit_q     <= res_ok;
                cnt          <= res_cyc;
            end else if (MDUSelect == SEL_MTHI) begin
                hi_q <= A;
            end else if (MDUSelect == SEL_MTLO) begin
                lo_q <= A;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Start;
    logic [2:0]  MDUSelect;
    logic [1:0]  MFSelect;
    logic [31:0] A, B;
    logic        Req;
    logic        Busy;
    logic [31:0] HI, LO, MDUOut;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: architectural HI/LO, cycles of Busy left, pending result.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_vld;
    int          m_left;

    mult_div_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Start     (Start),
        .MDUSelect (MDUSelect),
        .MFSelect  (MFSelect),
        .A         (A),
        .B         (B),
        .Req       (Req),
        .Busy      (Busy),
        .HI        (HI),
        .LO        (LO),
        .MDUOut    (MDUOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && Start && Busy)
            $error("FAIL start_while_busy got Start=1 with Busy=1");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_launch(input logic [2:0] sel);
`ifdef MDU_MADD_EN
        return (sel <= 3'b011) || (sel == 3'b110);
`else
        return (sel <= 3'b011);
`endif
    endfunction

    task automatic model_launch(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        p_vld = 1'b1;
        m_left = 5;
        p = 64'h0;
        case (sel)
            3'b000: p = 64'(sa * sb);
            3'b001: p = {32'h0, a} * {32'h0, b};
            3'b110: p = {m_hi, m_lo} + 64'(sa * sb);
            3'b010: begin
                m_left = 10;
                if (b == 32'h0) p_vld = 1'b0;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                m_left = 10;
                if (b == 32'h0) p_vld = 1'b0;
                else p = {a % b, a / b};
            end
        endcase
        {p_hi, p_lo} = p;
    endtask

    task automatic model_step();
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_vld) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (!Req) begin
            if (Start && is_launch(MDUSelect)) model_launch(MDUSelect, A, B);
            else if (MDUSelect == 3'b100) m_hi = A;
            else if (MDUSelect == 3'b101) m_lo = A;
        end
    endtask

    task automatic check_all();
        chk("busy", {31'h0, Busy}, {31'h0, (m_left > 0)});
        chk("hi", HI, m_hi);
        chk("lo", LO, m_lo);
        chk("mduout", MDUOut, (MFSelect == 2'b00) ? m_hi : (MFSelect == 2'b01) ? m_lo : 32'h0);
    endtask

    task automatic cycle(input logic st, input logic [2:0] sel, input logic [1:0] mf,
                         input logic [31:0] a, input logic [31:0] b, input logic rq);
        @(negedge clk);
        Start = st; MDUSelect = sel; MFSelect = mf; A = a; B = b; Req = rq;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 3'b111, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        reset_n = 1'b0; Start = 1'b0; MDUSelect = 3'b111; MFSelect = 2'b00;
        A = 32'h0; B = 32'h0; Req = 1'b0;
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_vld = 0; m_left = 0;
        #23;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // signed and unsigned multiply
        cycle(1'b1, 3'b000, 2'b00, 32'hFFFFFFFE, 32'h3, 1'b0);
        idle(5);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);
        cycle(1'b1, 3'b001, 2'b01, 32'hFFFFFFFE, 32'h3, 1'b0);
        idle(5);
        chk("multu_hi", HI, 32'h2);
        chk("multu_lo", LO, 32'hFFFFFFFA);

        // signed divide, divide by zero, overflow case
        cycle(1'b1, 3'b010, 2'b00, 32'hFFFFFFF9, 32'h2, 1'b0);
        idle(10);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);
        cycle(1'b1, 3'b011, 2'b00, 32'h7, 32'h0, 1'b0);
        idle(9);
        chk("divz_busy", {31'h0, Busy}, 32'h1);
        idle(1);
        chk("divz_lo", LO, 32'hFFFFFFFD);
        chk("divz_hi", HI, 32'hFFFFFFFF);
        cycle(1'b1, 3'b010, 2'b01, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        idle(10);
        chk("divov_lo", LO, 32'h80000000);
        chk("divov_hi", HI, 32'h0);

        // Req kills a launch but not an in-flight op
        cycle(1'b1, 3'b000, 2'b01, 32'h4, 32'h4, 1'b1);
        chk("req_kill_busy", {31'h0, Busy}, 32'h0);
        chk("req_kill_lo", LO, 32'h80000000);
        cycle(1'b1, 3'b000, 2'b01, 32'h4, 32'h4, 1'b0);
        idle(1);
        cycle(1'b0, 3'b111, 2'b01, 32'h0, 32'h0, 1'b1);
        idle(3);
        chk("req_busy_lo", LO, 32'd16);

        // mthi read back, mtlo ignored while busy
        cycle(1'b0, 3'b100, 2'b00, 32'h1234, 32'h0, 1'b0);
        cycle(1'b0, 3'b111, 2'b00, 32'h0, 32'h0, 1'b0);
        chk("mfhi_out", MDUOut, 32'h1234);
        cycle(1'b1, 3'b000, 2'b01, 32'h2, 32'h3, 1'b0);
        cycle(1'b0, 3'b101, 2'b01, 32'hDEAD, 32'h0, 1'b0);
        idle(4);
        chk("mtlo_busy_lo", LO, 32'h6);

        // madd, or its absence
        cycle(1'b0, 3'b100, 2'b00, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 3'b101, 2'b00, 32'hFFFFFFFF, 32'h0, 1'b0);
        cycle(1'b1, 3'b110, 2'b00, 32'h1, 32'h1, 1'b0);
`ifdef MDU_MADD_EN
        chk("madd_busy", {31'h0, Busy}, 32'h1);
        idle(5);
        chk("madd_hi", HI, 32'h1);
        chk("madd_lo", LO, 32'h0);
`else
        chk("madd_busy", {31'h0, Busy}, 32'h0);
        idle(1);
        chk("madd_hi", HI, 32'h0);
        chk("madd_lo", LO, 32'hFFFFFFFF);
`endif

        // async reset in the middle of a divide
        cycle(1'b0, 3'b100, 2'b00, 32'h55, 32'h0, 1'b0);
        cycle(1'b1, 3'b011, 2'b00, 32'd100, 32'd7, 1'b0);
        idle(6);
        chk("pre_rst_left", 32'(m_left), 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", {31'h0, Busy}, 32'h0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        m_hi = 0; m_lo = 0; m_left = 0; p_vld = 0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(12);
        chk("rst_no_commit_lo", LO, 32'h0);

        // random traffic; Start only when the model says the unit is idle
        for (int i = 0; i < 800; i++) begin
            logic [2:0] sel;
            logic       st;
            st  = 1'b0;
            sel = 3'($urandom_range(0, 7));
            if (m_left == 0 && $urandom_range(0, 2) == 0) begin
                st = 1'b1;
                case ($urandom_range(0, 4))
                    0: sel = 3'b000;
                    1: sel = 3'b001;
                    2: sel = 3'b010;
                    3: sel = 3'b011;
                    default: sel = 3'b110;
                endcase
            end else if (sel <= 3'b011 || sel == 3'b110) begin
                st = (m_left == 0) && ($urandom_range(0, 1) == 0);
            end
            cycle(st, sel, 2'($urandom_range(0, 3)), pick_val(), pick_val(),
                  ($urandom_range(0, 9) == 0));
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
